// File: rtl/pixel_fb_writer.sv
// Pixel stream consumer: buffers (x, y, colour) pixels in a small FIFO, translates them to
// linear framebuffer addresses and drives the framebuffer write port; also runs full-screen clears.
module pixel_fb_writer #(
    parameter int         FIFO_DEPTH   = 4,
    parameter int         SCREEN_W     = 160,
    parameter int         SCREEN_H     = 120,
    parameter logic [8:0] CLEAR_COLOUR = 9'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [8:0]  in_colour,
    input  logic        clear_req,
    output logic [14:0] fb_address,
    output logic [8:0]  fb_data,
    output logic        fb_wren,
    output logic        busy,
    output logic        clear_done,
    output logic [7:0]  drop_count
);

    localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [14:0] LAST_ADDR  = 15'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] colour;
    } pixel_t;

    state_t        state_q, state_d;

    pixel_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;

    logic          stValid_q, stValid_d;
    pixel_t        stPix_q, stPix_d;

    logic [14:0]   fbAddr_q, fbAddr_d;
    logic [8:0]    fbData_q, fbData_d;
    logic          fbWren_q, fbWren_d;
    logic          clearWrite_q, clearWrite_d;
    logic          clearDone_q, clearDone_d;
    logic [14:0]   clearAddr_q, clearAddr_d;
    logic [7:0]    dropCount_q, dropCount_d;

    logic          fifoEmpty;
    logic          fifoFull;
    logic          push;
    logic          pop;
    logic          inRange;
    logic [14:0]   yWide;
    logic [14:0]   pixAddr;
    pixel_t        pixIn;

    assign fifoEmpty = (count_q == '0);
    assign fifoFull  = (count_q == FULL_COUNT);
    assign in_ready  = !reset && (state_q == RUN) && !fifoFull;
    assign push      = in_valid && in_ready;
    assign pop       = !fifoEmpty && (state_q != CLEAR);
    assign pixIn     = '{x: in_x, y: in_y, colour: in_colour};

    // y*160 as a shift-add; the 15-bit width holds the largest reachable sum without wrap.
    assign yWide   = 15'(stPix_q.y);
    assign pixAddr = (yWide << 7) + (yWide << 5) + 15'(stPix_q.x);
    assign inRange = (32'(stPix_q.x) < SCREEN_W) && (32'(stPix_q.y) < SCREEN_H);

    assign fb_address = fbAddr_q;
    assign fb_data    = fbData_q;
    assign fb_wren    = fbWren_q;
    assign clear_done = clearDone_q;
    assign drop_count = dropCount_q;
    assign busy       = (state_q != RUN) || !fifoEmpty || stValid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (clear_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifoEmpty && !stValid_q) state_d = CLEAR;
            end
            CLEAR: begin
                if (clearAddr_q == LAST_ADDR) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Storage has no reset: the pointers and count alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wrPtr_q] <= pixIn;
    end

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        stValid_d = pop;
        stPix_d   = stPix_q;
        if (push) wrPtr_d = wrPtr_q + 1'b1;
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
            stPix_d = mem_q[rdPtr_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            stValid_q <= 1'b0;
            stPix_q   <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            stValid_q <= stValid_d;
            stPix_q   <= stPix_d;
        end
    end

    // Clear writes take priority; the translate stage is always empty by the time CLEAR is entered.
    always_comb begin
        fbAddr_d     = fbAddr_q;
        fbData_d     = fbData_q;
        fbWren_d     = 1'b0;
        clearWrite_d = 1'b0;
        clearAddr_d  = '0;
        dropCount_d  = dropCount_q;
        clearDone_d  = clearWrite_q && (fbAddr_q == LAST_ADDR);
        if (state_q == CLEAR) begin
            fbWren_d     = 1'b1;
            fbAddr_d     = clearAddr_q;
            fbData_d     = CLEAR_COLOUR;
            clearWrite_d = 1'b1;
            clearAddr_d  = clearAddr_q + 15'd1;
        end else if (stValid_q) begin
            if (inRange) begin
                fbWren_d = 1'b1;
                fbAddr_d = pixAddr;
                fbData_d = stPix_q.colour;
            end else if (dropCount_q != 8'hFF) begin
                dropCount_d = dropCount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fbAddr_q     <= '0;
            fbData_q     <= '0;
            fbWren_q     <= 1'b0;
            clearWrite_q <= 1'b0;
            clearDone_q  <= 1'b0;
            clearAddr_q  <= '0;
            dropCount_q  <= '0;
        end else begin
            fbAddr_q     <= fbAddr_d;
            fbData_q     <= fbData_d;
            fbWren_q     <= fbWren_d;
            clearWrite_q <= clearWrite_d;
            clearDone_q  <= clearDone_d;
            clearAddr_q  <= clearAddr_d;
            dropCount_q  <= dropCount_d;
        end
    end

endmodule

// File: tb/tb_pixel_fb_writer.sv
// Directed bench for pixel_fb_writer: a scoreboard queue of expected framebuffer writes is
// filled as pixels are sent and drained by a monitor that also tracks clear sweeps.
module tb_pixel_fb_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_x = '0;
    logic [6:0]  in_y = '0;
    logic [8:0]  in_colour = '0;
    logic        clear_req = 1'b0;
    logic [14:0] fb_address;
    logic [8:0]  fb_data;
    logic        fb_wren;
    logic        busy;
    logic        clear_done;
    logic [7:0]  drop_count;

    typedef struct packed {
        logic [14:0] addr;
        logic [8:0]  data;
    } wr_t;

    wr_t expQ[$];
    int  total = 0;
    int  bad = 0;
    int  writeCount = 0;
    int  lastAddr = -1;
    int  stallCycles = 0;
    int  clearArmed = 0;
    int  clearNext = 0;
    int  clearWrites = 0;
    int  clearDones = 0;

    pixel_fb_writer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .clear_req  (clear_req),
        .fb_address (fb_address),
        .fb_data    (fb_data),
        .fb_wren    (fb_wren),
        .busy       (busy),
        .clear_done (clear_done),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #900us;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pixel writes drain the scoreboard first; any other write must belong to an armed clear sweep.
    always @(negedge clk) begin
        if (!reset) begin
            if (fb_wren) begin
                if (expQ.size() != 0) begin
                    wr_t e;
                    e = expQ.pop_front();
                    total++;
                    assert (fb_address === e.addr) else begin
                        bad++;
                        $error("[TB] FAIL write_addr observed=%0d expected=%0d", fb_address, e.addr);
                    end
                    total++;
                    assert (fb_data === e.data) else begin
                        bad++;
                        $error("[TB] FAIL write_data observed=%0h expected=%0h", fb_data, e.data);
                    end
                    writeCount++;
                    lastAddr = int'(fb_address);
                end else if (clearArmed != 0) begin
                    total++;
                    assert (fb_address === 15'(clearNext)) else begin
                        bad++;
                        $error("[TB] FAIL clear_addr observed=%0d expected=%0d", fb_address, clearNext);
                    end
                    total++;
                    assert (fb_data === 9'h000) else begin
                        bad++;
                        $error("[TB] FAIL clear_data observed=%0h expected=0", fb_data);
                    end
                    clearNext++;
                    clearWrites++;
                end else begin
                    total++;
                    assert (fb_wren === 1'b0) else begin
                        bad++;
                        $error("[TB] FAIL unexpected_write observed=addr %0d expected=no write", fb_address);
                    end
                end
            end else if (clearArmed != 0 && clearNext > 0 && clearNext < 19200) begin
                total++;
                assert (fb_wren === 1'b1) else begin
                    bad++;
                    $error("[TB] FAIL clear_gap observed=0 expected=1 at addr %0d", clearNext);
                end
            end
            if (clear_done) begin
                clearDones++;
                total++;
                assert (clearNext === 19200) else begin
                    bad++;
                    $error("[TB] FAIL clear_done_timing observed=%0d expected=19200", clearNext);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge with in_valid still high.
    task automatic applyStimulus(input logic [7:0] x, input logic [6:0] y, input logic [8:0] c,
                                 input logic withClear);
        int waitCycles;
        waitCycles = 0;
        in_x = x;
        in_y = y;
        in_colour = c;
        in_valid = 1'b1;
        while (!in_ready && waitCycles < 200) begin
            stallCycles++;
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("handshake_timeout", 32'(in_ready), 32'd1);
        end else begin
            if (int'(x) < 160 && int'(y) < 120)
                expQ.push_back('{addr: 15'(int'(y) * 160 + int'(x)), data: c});
            clear_req = withClear;
            @(posedge clk);
            #1;
            clear_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic waitWrites(input string tag);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(expQ.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkSinglePixel(input string tag);
        applyStimulus(8'd5, 7'd3, 9'h1C0, 1'b0);
        in_valid = 1'b0;
        checkOutput({tag, "_wren_n0"}, 32'(fb_wren), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_wren_n1"}, 32'(fb_wren), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_wren_n2"}, 32'(fb_wren), 32'd1);
        checkOutput({tag, "_addr"}, 32'(fb_address), 32'd485);
        checkOutput({tag, "_data"}, 32'(fb_data), 32'h1C0);
        @(negedge clk);
        checkOutput({tag, "_wren_after"}, 32'(fb_wren), 32'd0);
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_wren", 32'(fb_wren), 32'd0);
        checkOutput("rst_addr", 32'(fb_address), 32'd0);
        checkOutput("rst_data", 32'(fb_data), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(clear_done), 32'd0);
        checkOutput("rst_drop", 32'(drop_count), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single pixel, two-cycle latency
        checkSinglePixel("t1");

        // 20x20 tile streamed back to back
        $display("[TB] tile stream");
        base = writeCount;
        stallCycles = 0;
        for (int y = 20; y < 40; y++)
            for (int x = 40; x < 60; x++)
                applyStimulus(8'(x), 7'(y), 9'(x * 7 + y), 1'b0);
        in_valid = 1'b0;
        waitWrites("t2_drain");
        checkOutput("t2_count", 32'(writeCount - base), 32'd400);
        checkOutput("t2_last_addr", 32'(lastAddr), 32'd6299);
        checkOutput("t2_stalls", 32'(stallCycles), 32'd0);

        // Boundary pixel at the far corner
        applyStimulus(8'd159, 7'd119, 9'h0AA, 1'b0);
        in_valid = 1'b0;
        waitWrites("corner_drain");
        checkOutput("corner_addr", 32'(lastAddr), 32'd19199);

        // Queued pixels then clear: pixels must land before clear address 0
        $display("[TB] drain then clear");
        base = writeCount;
        clearArmed = 1;
        clearNext = 0;
        clearWrites = 0;
        clearDones = 0;
        applyStimulus(8'd1, 7'd1, 9'h101, 1'b0);
        applyStimulus(8'd2, 7'd2, 9'h102, 1'b0);
        applyStimulus(8'd3, 7'd3, 9'h103, 1'b0);
        applyStimulus(8'd4, 7'd4, 9'h104, 1'b1);
        in_valid = 1'b0;
        checkOutput("t3_in_ready_drain", 32'(in_ready), 32'd0);
        checkOutput("t3_busy", 32'(busy), 32'd1);
        n = 0;
        while (clearDones == 0 && n < 20500) begin
            @(negedge clk);
            n++;
            if (n == 100) clear_req = 1'b1;
            if (n == 101) clear_req = 1'b0;
        end
        checkOutput("t3_pixels_before_clear", 32'(writeCount - base), 32'd4);
        checkOutput("t4_done_seen", 32'(clearDones), 32'd1);
        checkOutput("t4_clear_writes", 32'(clearWrites), 32'd19200);
        repeat (5) @(negedge clk);
        clearArmed = 0;
        checkOutput("t4_done_once", 32'(clearDones), 32'd1);
        checkOutput("t4_busy_idle", 32'(busy), 32'd0);
        checkOutput("t4_in_ready", 32'(in_ready), 32'd1);

        // Out-of-range pixels are dropped and counted, saturating
        $display("[TB] range check");
        applyStimulus(8'd160, 7'd0, 9'h1FF, 1'b0);
        applyStimulus(8'd0, 7'd120, 9'h1FF, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_drop2", 32'(drop_count), 32'd2);
        for (int i = 0; i < 300; i++)
            applyStimulus(8'(200 + (i % 50)), 7'(i % 128), 9'(i), 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t5_drop_sat", 32'(drop_count), 32'd255);

        // Reset in the middle of a clear
        $display("[TB] reset mid-clear");
        clearArmed = 1;
        clearNext = 0;
        clearWrites = 0;
        clearDones = 0;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        n = 0;
        while (clearNext < 5000 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t6_reached_5000", 32'(clearNext >= 5000), 32'd1);
        clearArmed = 0;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_wren", 32'(fb_wren), 32'd0);
        checkOutput("t6_rst_addr", 32'(fb_address), 32'd0);
        checkOutput("t6_rst_data", 32'(fb_data), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("t6_rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("t6_no_done", 32'(clearDones), 32'd0);
        checkSinglePixel("t6");
        waitWrites("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
